// File: rtl/stage2_fmap_collector.sv
// Collects one OUT_H x OUT_W x CO feature map from the stage-2 conv stream.
// The map is then replayed channel-major, one signed word per valid/ready beat.
module stage2_fmap_collector #(
  parameter int CO    = 3,
  parameter int BW    = 20,
  parameter int OUT_W = 8,
  parameter int OUT_H = 8,
  localparam int IDXW = $clog2(CO*OUT_H*OUT_W)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_in_valid,
  input  logic [CO*BW-1:0]   i_in_fmap,
  output logic               o_ot_valid,
  output logic [BW-1:0]      o_ot_data,
  output logic [IDXW-1:0]    o_ot_index,
  output logic               o_ot_last,
  input  logic               i_ot_ready,
  output logic               o_busy,
  output logic               o_overflow
);

  localparam int NPIX = OUT_H*OUT_W;
  localparam int NOUT = CO*NPIX;
  localparam int PIXW = $clog2(NPIX);
  localparam int CHW  = (CO > 1) ? $clog2(CO) : 1;
  localparam logic [PIXW-1:0] PIX_LAST = PIXW'(NPIX-1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NOUT-1);

  typedef enum logic {COLLECT, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [PIXW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [PIXW-1:0]   pix_q, pix_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [IDXW-1:0]   rd_cnt_q, rd_cnt_d;
  logic              overflow_q, overflow_d;
  logic              wr_en;
  logic [CO*BW-1:0]  buf_q [NPIX];
  logic [BW-1:0]     chan_word [CO];

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    pix_d      = pix_q;
    ch_d       = ch_q;
    rd_cnt_d   = rd_cnt_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    case (state_q)
      COLLECT: begin
        if (i_in_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == PIX_LAST) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            pix_d    = '0;
            ch_d     = '0;
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Points arriving while draining are dropped; only the sticky flag records them.
        if (i_in_valid) overflow_d = 1'b1;
        if (i_ot_ready) begin
          if (rd_cnt_q == IDX_LAST) begin
            rd_cnt_d = '0;
            pix_d    = '0;
            ch_d     = '0;
            state_d  = COLLECT;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (pix_q == PIX_LAST) begin
              pix_d = '0;
              ch_d  = ch_q + 1'b1;
            end else begin
              pix_d = pix_q + 1'b1;
            end
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= COLLECT;
      wr_cnt_q   <= '0;
      pix_q      <= '0;
      ch_q       <= '0;
      rd_cnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      pix_q      <= pix_d;
      ch_q       <= ch_d;
      rd_cnt_q   <= rd_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame buffer is deliberately unreset; its contents only reach the output in DRAIN.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_cnt_q] <= i_in_fmap;
  end

  always_comb begin
    for (int c = 0; c < CO; c++) chan_word[c] = buf_q[pix_q][c*BW +: BW];
  end

  assign o_ot_valid = (state_q == DRAIN);
  assign o_busy     = (state_q == DRAIN);
  assign o_ot_data  = (state_q == DRAIN) ? chan_word[ch_q] : '0;
  assign o_ot_index = rd_cnt_q;
  assign o_ot_last  = (state_q == DRAIN) && (rd_cnt_q == IDX_LAST);
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_stage2_fmap_collector.sv
// Self-checking bench for stage2_fmap_collector: frame patterns from a table,
// random backpressure, overflow, reset mid-drain and back-to-back frames.
module tb_stage2_fmap_collector;

  localparam int CO    = 3;
  localparam int BW    = 20;
  localparam int OUT_W = 8;
  localparam int OUT_H = 8;
  localparam int NPIX  = OUT_H*OUT_W;
  localparam int NOUT  = CO*NPIX;
  localparam int IDXW  = $clog2(NOUT);

  logic              clk;
  logic              reset_n;
  logic              i_in_valid;
  logic [CO*BW-1:0]  i_in_fmap;
  logic              o_ot_valid;
  logic [BW-1:0]     o_ot_data;
  logic [IDXW-1:0]   o_ot_index;
  logic              o_ot_last;
  logic              i_ot_ready;
  logic              o_busy;
  logic              o_overflow;

  stage2_fmap_collector #(.CO(CO), .BW(BW), .OUT_W(OUT_W), .OUT_H(OUT_H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_valid (i_in_valid),
    .i_in_fmap  (i_in_fmap),
    .o_ot_valid (o_ot_valid),
    .o_ot_data  (o_ot_data),
    .o_ot_index (o_ot_index),
    .o_ot_last  (o_ot_last),
    .i_ot_ready (i_ot_ready),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the captured frame plus the expected sticky overflow flag.
  logic [BW-1:0] frameVals [NPIX][CO];
  bit            ovfModel;
  int            testCount;
  int            failCount;

  typedef struct {
    int kind;
    int readyPct;
    int ovfMode;
    bit expOvf;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"},    {63'd0, o_ot_valid}, 64'd0);
    checkOutput({tag, "_data"},     {44'd0, o_ot_data},  64'd0);
    checkOutput({tag, "_index"},    {56'd0, o_ot_index}, 64'd0);
    checkOutput({tag, "_last"},     {63'd0, o_ot_last},  64'd0);
    checkOutput({tag, "_busy"},     {63'd0, o_busy},     64'd0);
    checkOutput({tag, "_overflow"}, {63'd0, o_overflow}, 64'd0);
  endtask

  // Fills the model frame for a pattern kind, then streams it one point per cycle.
  task automatic applyStimulus(input int kind);
    logic [63:0] r;
    for (int p = 0; p < NPIX; p++) begin
      for (int c = 0; c < CO; c++) begin
        case (kind)
          0: frameVals[p][c] = BW'(c*1000 + p);
          1: frameVals[p][c] = ((p + c) % 2 == 1) ? 20'h7FFFF : 20'h80000;
          2: frameVals[p][c] = BW'(p + 7);
          default: begin
            r = {32'd0, $urandom()};
            frameVals[p][c] = r[BW-1:0];
          end
        endcase
      end
    end
    for (int p = 0; p < NPIX; p++) begin
      i_in_valid = 1'b1;
      for (int c = 0; c < CO; c++) i_in_fmap[c*BW +: BW] = frameVals[p][c];
      @(posedge clk); #1;
      if (p < NPIX-1) checkOutput("validEarly", {63'd0, o_ot_valid}, 64'd0);
    end
    i_in_valid = 1'b0;
  endtask

  // Drains one frame. ovfMode 1 drops 5 points early in the drain, ovfMode 2 drops
  // one point on the final handshake cycle. abortAt>=0 returns when that word is shown.
  task automatic drainFrame(input int readyPct, input int ovfMode, input int abortAt);
    int k;
    int cyc;
    int c;
    int p;
    bit rdy;
    bit dropIn;
    logic [63:0] r;
    k = 0;
    cyc = 0;
    while (k < NOUT && cyc < 4000) begin
      c = k / NPIX;
      p = k % NPIX;
      checkOutput("valid",    {63'd0, o_ot_valid}, 64'd1);
      checkOutput("busy",     {63'd0, o_busy},     64'd1);
      checkOutput("data",     {44'd0, o_ot_data},  {44'd0, frameVals[p][c]});
      checkOutput("index",    {56'd0, o_ot_index}, 64'(k));
      checkOutput("last",     {63'd0, o_ot_last},  {63'd0, (k == NOUT-1)});
      checkOutput("overflow", {63'd0, o_overflow}, {63'd0, ovfModel});
      if (abortAt >= 0 && k == abortAt) return;
      rdy = ($urandom_range(99) < readyPct);
      dropIn = (ovfMode == 1 && cyc < 5) || (ovfMode == 2 && rdy && k == NOUT-1);
      i_ot_ready = rdy;
      i_in_valid = dropIn;
      r = {$urandom(), $urandom()};
      i_in_fmap = r[CO*BW-1:0];
      @(posedge clk); #1;
      if (dropIn) ovfModel = 1'b1;
      if (rdy) k++;
      cyc++;
    end
    i_ot_ready = 1'b0;
    i_in_valid = 1'b0;
    if (cyc >= 4000) checkOutput("drainTimeout", 64'(k), 64'(NOUT));
    checkOutput("validAfterDrain",    {63'd0, o_ot_valid}, 64'd0);
    checkOutput("overflowAfterDrain", {63'd0, o_overflow}, {63'd0, ovfModel});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    testCount  = 0;
    failCount  = 0;
    ovfModel   = 1'b0;
    reset_n    = 1'b1;
    i_in_valid = 1'b0;
    i_in_fmap  = '0;
    i_ot_ready = 1'b0;

    // Scenario table: pattern kind, ready percentage, overflow injection, expected flag.
    vecs[0] = '{kind: 0, readyPct: 100, ovfMode: 0, expOvf: 1'b0};
    vecs[1] = '{kind: 0, readyPct: 50,  ovfMode: 0, expOvf: 1'b0};
    vecs[2] = '{kind: 1, readyPct: 100, ovfMode: 0, expOvf: 1'b0};
    vecs[3] = '{kind: 3, readyPct: 40,  ovfMode: 0, expOvf: 1'b0};
    vecs[4] = '{kind: 2, readyPct: 100, ovfMode: 0, expOvf: 1'b0};
    vecs[5] = '{kind: 0, readyPct: 100, ovfMode: 1, expOvf: 1'b1};
    vecs[6] = '{kind: 3, readyPct: 60,  ovfMode: 0, expOvf: 1'b1};

    #2 reset_n = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    checkResetOutputs("postReset");

    // Each frame starts right after the previous drain, exercising back-to-back frames.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].kind);
      drainFrame(vecs[i].readyPct, vecs[i].ovfMode, -1);
      checkOutput($sformatf("tableOvf%0d", i), {63'd0, o_overflow}, {63'd0, vecs[i].expOvf});
    end

    // Reset asserted while word 70 is on the output must clear everything at once.
    applyStimulus(0);
    drainFrame(50, 0, 70);
    #2 reset_n = 1'b0;
    i_ot_ready = 1'b0;
    #1 checkResetOutputs("midDrainReset");
    ovfModel = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(2);
    drainFrame(100, 0, -1);

    // A point on the final handshake cycle is dropped and must not shift the next frame.
    applyStimulus(0);
    drainFrame(100, 2, -1);
    checkOutput("lastBeatOvf", {63'd0, o_overflow}, 64'd1);
    applyStimulus(3);
    drainFrame(70, 0, -1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
